// File: rtl/scp_pkg.sv
// Shared definitions for the simple computer and its program loader:
// frame header constant, byte/address types and the loader state encoding.
package scp_pkg;

    localparam logic [7:0] HDR = 8'hA5;

    typedef logic [7:0] byte_t;
    typedef logic [7:0] addr_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_LEN  = 3'd2,
        GET_DATA = 3'd3,
        W_SETUP  = 3'd4,
        W_STROBE = 3'd5,
        W_HOLD   = 3'd6,
        GET_CSUM = 3'd7
    } loader_state_e;

    // States in which a host byte can be accepted.
    function automatic logic accepts_byte(input loader_state_e s);
        return !(s == W_SETUP || s == W_STROBE || s == W_HOLD);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes payload bytes into CPU memory through the
// memory-edit port and holds the CPU in reset until a frame checksums good.
module prog_loader
    import scp_pkg::*;
(
    input  logic       CLK,
    input  logic       AR,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_RDY,
    output logic [7:0] MEM_ADDR,
    output logic [7:0] MEM_DATA,
    output logic       MEM_EDIT,
    output logic       CPU_AR,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    loader_state_e state_q, state_d;
    addr_t         addr_q, addr_d;
    byte_t         cnt_q, cnt_d;
    byte_t         sum_q, sum_d;
    addr_t         mem_addr_q, mem_addr_d;
    byte_t         mem_data_q, mem_data_d;
    logic          cpu_ar_q, cpu_ar_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          xfer;

    assign xfer = IN_VALID && accepts_byte(state_q);

    always_ff @(posedge CLK or negedge AR) begin
        if (!AR) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            cpu_ar_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_ar_q   <= cpu_ar_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        cpu_ar_d   = cpu_ar_q;
        done_d     = done_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                // Non-header bytes are swallowed so the link can resync on HDR.
                if (xfer && IN_DATA == HDR) begin
                    state_d  = GET_ADDR;
                    cpu_ar_d = 1'b0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            GET_ADDR: begin
                if (xfer) begin
                    addr_d  = IN_DATA;
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (xfer) begin
                    cnt_d   = IN_DATA;
                    sum_d   = '0;
                    state_d = (IN_DATA == 8'd0) ? GET_CSUM : GET_DATA;
                end
            end
            GET_DATA: begin
                if (xfer) begin
                    mem_data_d = IN_DATA;
                    mem_addr_d = addr_q;
                    sum_d      = sum_q + IN_DATA;
                    state_d    = W_SETUP;
                end
            end
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = W_HOLD;
            W_HOLD: begin
                addr_d  = addr_q + 8'd1;
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? GET_CSUM : GET_DATA;
            end
            GET_CSUM: begin
                if (xfer) begin
                    if (IN_DATA == sum_q) begin
                        done_d   = 1'b1;
                        cpu_ar_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe and busy decode straight from state so reset drops them at once.
    assign IN_RDY   = accepts_byte(state_q);
    assign MEM_EDIT = (state_q == W_STROBE);
    assign BUSY     = (state_q != IDLE);
    assign MEM_ADDR = mem_addr_q;
    assign MEM_DATA = mem_data_q;
    assign CPU_AR   = cpu_ar_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are pushed byte by byte and the
// memory-edit strobes are captured by a monitor for comparison.
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       AR = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_VALID = 1'b0;
    logic       IN_RDY;
    logic [7:0] MEM_ADDR;
    logic [7:0] MEM_DATA;
    logic       MEM_EDIT;
    logic       CPU_AR;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         n_edit = 0;
    logic [7:0] ea [0:63];
    logic [7:0] ed [0:63];
    int         ec [0:63];

    logic [7:0] fq [$];

    prog_loader dut (
        .CLK      (CLK),
        .AR       (AR),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_RDY   (IN_RDY),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA),
        .MEM_EDIT (MEM_EDIT),
        .CPU_AR   (CPU_AR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Capture every cycle in which the write strobe is high.
    always @(negedge CLK) begin
        if (MEM_EDIT === 1'b1 && n_edit < 64) begin
            ea[n_edit] = MEM_ADDR;
            ed[n_edit] = MEM_DATA;
            ec[n_edit] = cyc;
            n_edit     = n_edit + 1;
        end
    end

    // Present one byte and return #1 after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        IN_DATA  = b;
        IN_VALID = 1'b1;
        while (IN_RDY !== 1'b1 && guard < 10) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        n_checks++;
        if (guard >= 10) begin
            n_fail++;
            $display("FAIL send_timeout: IN_RDY=%b after %0d cycles, required 1", IN_RDY, guard);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic send_queue();
        foreach (fq[i]) send_byte(fq[i]);
    endtask

    task automatic check_writes(input string name, input int base,
                                input logic [7:0] xa [0:3], input logic [7:0] xd [0:3],
                                input int n);
        n_checks++;
        if (n_edit - base !== n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, required %0d", name, n_edit - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (ea[base+i] !== xa[i] || ed[base+i] !== xd[i]) begin
                    n_fail++;
                    $display("FAIL %s_write%0d: got %h<-%h, required %h<-%h",
                             name, i, ea[base+i], ed[base+i], xa[i], xd[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (ec[base+i] - ec[base+i-1] !== 4) begin
                        n_fail++;
                        $display("FAIL %s_spacing%0d: got %0d cycles, required 4",
                                 name, i, ec[base+i] - ec[base+i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        AR = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        AR = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({CPU_AR, IN_RDY, BUSY, DONE, ERR, MEM_EDIT} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_flags: got CPU_AR,IN_RDY,BUSY,DONE,ERR,EDIT=%b, required 010000",
                     {CPU_AR, IN_RDY, BUSY, DONE, ERR, MEM_EDIT});
        end
        n_checks++;
        if ({MEM_ADDR, MEM_DATA} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%h data=%h, required 00/00", MEM_ADDR, MEM_DATA);
        end
        $display("txn reset: CPU_AR=%b IN_RDY=%b BUSY=%b", CPU_AR, IN_RDY, BUSY);
    endtask

    task automatic test_basic_load();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        base = n_edit;
        fq = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_queue();
        xa = '{8'h10, 8'h11, 8'h12, 8'h00};
        xd = '{8'h11, 8'h22, 8'h33, 8'h00};
        check_writes("basic", base, xa, xd, 3);
        n_checks++;
        if ({DONE, ERR, CPU_AR, BUSY} !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_status: got DONE,ERR,CPU_AR,BUSY=%b, required 1010",
                     {DONE, ERR, CPU_AR, BUSY});
        end
        n_checks++;
        if ({MEM_ADDR, MEM_DATA} !== 16'h1233) begin
            n_fail++;
            $display("FAIL basic_hold: got addr=%h data=%h, required 12/33", MEM_ADDR, MEM_DATA);
        end
        $display("txn basic: %0d writes DONE=%b CPU_AR=%b", n_edit - base, DONE, CPU_AR);
    endtask

    task automatic test_hdr_while_running();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        base = n_edit;
        send_byte(8'hA5);
        n_checks++;
        if ({CPU_AR, DONE, BUSY} !== 3'b001) begin
            n_fail++;
            $display("FAIL hdr_run: got CPU_AR,DONE,BUSY=%b, required 001", {CPU_AR, DONE, BUSY});
        end
        fq = '{8'h70, 8'h01, 8'h05, 8'h05};
        send_queue();
        xa = '{8'h70, 8'h00, 8'h00, 8'h00};
        xd = '{8'h05, 8'h00, 8'h00, 8'h00};
        check_writes("hdr_run", base, xa, xd, 1);
        n_checks++;
        if ({DONE, CPU_AR} !== 2'b11) begin
            n_fail++;
            $display("FAIL hdr_run_done: got DONE,CPU_AR=%b, required 11", {DONE, CPU_AR});
        end
        $display("txn hdr_while_running: CPU_AR=%b DONE=%b", CPU_AR, DONE);
    endtask

    task automatic test_addr_wrap();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        base = n_edit;
        fq = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
        send_queue();
        xa = '{8'hFE, 8'hFF, 8'h00, 8'h00};
        xd = '{8'h01, 8'h02, 8'h03, 8'h00};
        check_writes("wrap", base, xa, xd, 3);
        n_checks++;
        if ({DONE, ERR, CPU_AR} !== 3'b101) begin
            n_fail++;
            $display("FAIL wrap_status: got DONE,ERR,CPU_AR=%b, required 101", {DONE, ERR, CPU_AR});
        end
        $display("txn addr_wrap: %0d writes DONE=%b", n_edit - base, DONE);
    endtask

    task automatic test_bad_csum();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        base = n_edit;
        fq = '{8'hA5, 8'h20, 8'h02, 8'h01, 8'h02, 8'h00};
        send_queue();
        xa = '{8'h20, 8'h21, 8'h00, 8'h00};
        xd = '{8'h01, 8'h02, 8'h00, 8'h00};
        check_writes("badcsum", base, xa, xd, 2);
        n_checks++;
        if ({DONE, ERR, CPU_AR, BUSY} !== 4'b0100) begin
            n_fail++;
            $display("FAIL badcsum_status: got DONE,ERR,CPU_AR,BUSY=%b, required 0100",
                     {DONE, ERR, CPU_AR, BUSY});
        end
        $display("txn bad_csum: ERR=%b DONE=%b CPU_AR=%b", ERR, DONE, CPU_AR);
    endtask

    task automatic test_zero_len();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        base = n_edit;
        send_byte(8'h00);
        send_byte(8'h7F);
        n_checks++;
        if ({BUSY, IN_RDY, ERR} !== 3'b011) begin
            n_fail++;
            $display("FAIL discard_idle: got BUSY,IN_RDY,ERR=%b, required 011", {BUSY, IN_RDY, ERR});
        end
        fq = '{8'hA5, 8'h40, 8'h00, 8'h00};
        send_queue();
        xa = '{8'h00, 8'h00, 8'h00, 8'h00};
        xd = '{8'h00, 8'h00, 8'h00, 8'h00};
        check_writes("zerolen", base, xa, xd, 0);
        n_checks++;
        if ({DONE, ERR, CPU_AR, BUSY} !== 4'b1010) begin
            n_fail++;
            $display("FAIL zerolen_status: got DONE,ERR,CPU_AR,BUSY=%b, required 1010",
                     {DONE, ERR, CPU_AR, BUSY});
        end
        $display("txn zero_len: %0d writes DONE=%b", n_edit - base, DONE);
    endtask

    task automatic test_reset_mid_strobe();
        int base;
        logic [7:0] xa [0:3];
        logic [7:0] xd [0:3];
        fq = '{8'hA5, 8'h50, 8'h03, 8'hAA, 8'hBB};
        send_queue();
        // BB accepted: one cycle of setup, then the strobe.
        @(posedge CLK);
        #1;
        n_checks++;
        if ({MEM_EDIT, IN_RDY, MEM_ADDR, MEM_DATA} !== {1'b1, 1'b0, 8'h51, 8'hBB}) begin
            n_fail++;
            $display("FAIL mid_strobe: got EDIT=%b IN_RDY=%b %h<-%h, required 1 0 51<-BB",
                     MEM_EDIT, IN_RDY, MEM_ADDR, MEM_DATA);
        end
        AR = 1'b0;
        #1;
        n_checks++;
        if ({MEM_EDIT, BUSY, CPU_AR, IN_RDY, DONE, ERR} !== 6'b000100) begin
            n_fail++;
            $display("FAIL async_reset: got EDIT,BUSY,CPU_AR,IN_RDY,DONE,ERR=%b, required 000100",
                     {MEM_EDIT, BUSY, CPU_AR, IN_RDY, DONE, ERR});
        end
        n_checks++;
        if ({MEM_ADDR, MEM_DATA} !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_mem: got %h/%h, required 00/00", MEM_ADDR, MEM_DATA);
        end
        @(negedge CLK);
        AR = 1'b1;
        @(posedge CLK);
        #1;
        base = n_edit;
        fq = '{8'hA5, 8'h60, 8'h02, 8'h0F, 8'hF0, 8'hFF};
        send_queue();
        xa = '{8'h60, 8'h61, 8'h00, 8'h00};
        xd = '{8'h0F, 8'hF0, 8'h00, 8'h00};
        check_writes("after_reset", base, xa, xd, 2);
        n_checks++;
        if ({DONE, ERR, CPU_AR} !== 3'b101) begin
            n_fail++;
            $display("FAIL after_reset_status: got DONE,ERR,CPU_AR=%b, required 101",
                     {DONE, ERR, CPU_AR});
        end
        $display("txn reset_mid_strobe: reload %0d writes DONE=%b", n_edit - base, DONE);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_hdr_while_running();
        test_addr_wrap();
        test_bad_csum();
        test_zero_len();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
